mdu_seq: RTL
============

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port i_Valid_1, input, 1, request valid from the decode stage.
REQ-005 SHALL have port o_Ready_1, output, 1, high when a request can be accepted.
REQ-006 SHALL have port i_MDUOp_3, input, 3, operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports i_Operand1_32 and i_Operand2_32, input, 32 each, rs1 and rs2 values.
REQ-008 SHALL have port i_Flush_1, input, 1, aborts any in-flight operation.
REQ-009 SHALL have port o_Busy_1, output, 1, pipeline stall while an operation is in flight.
REQ-010 SHALL have port o_Done_1, output, 1, one-cycle result-valid pulse.
REQ-011 SHALL have port o_Result_32, output, 32, result; held until the next acceptance.

Function
REQ-012 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-013 o_Ready_1 SHALL equal (state==IDLE); a request SHALL be accepted only when i_Valid_1, o_Ready_1 and ~i_Flush_1 are all high in the same cycle.
REQ-014 SHALL latch the operation and both operands at acceptance; input changes after acceptance SHALL have no effect.
REQ-015 SHALL ignore i_Valid_1 in any state other than IDLE.
REQ-016 Normal path, for acceptance at cycle N:
- N+1 through N+32: CALC, one iteration per cycle, with a 6-bit counter counting 0 to 31.
- N+33: FIX, sign correction.
- N+34: DONE, o_Done_1 high for exactly one cycle.
- N+35: return to IDLE.
REQ-017 Multiply SHALL work on operand magnitudes (op1 signed for MUL/MULH/MULHSU; op2 signed for MUL/MULH) using 32-step shift-add into a 64-bit product, and SHALL negate the product in FIX when the operand signs differ.
- MUL returns product[31:0].
- MULH, MULHSU and MULHU return product[63:32].
REQ-018 Divide SHALL use 32-step restoring division on magnitudes.
- Quotient sign is sign(op1) XOR sign(op2).
- Remainder sign is sign(op1).
REQ-019 Fast path: for divisor==0 or (DIV/REM with op1==0x80000000 and op2==0xFFFFFFFF), the block SHALL go IDLE->DONE, giving o_Done_1 at N+1.
- Divisor zero: quotient 0xFFFFFFFF, remainder = op1.
- Overflow: quotient 0x80000000, remainder 0.
REQ-020 o_Busy_1 SHALL be high in CALC and FIX, and in the acceptance cycle (combinationally); it SHALL be low in IDLE otherwise and in DONE.
REQ-021 i_Flush_1 high in any state SHALL force IDLE on the next edge, with no o_Done_1 pulse and o_Result_32 unchanged; a flush in the DONE cycle SHALL NOT suppress the pulse already in progress.
REQ-022 All counter and product arithmetic SHALL wrap modulo its declared width; the iteration count SHALL NOT depend on operand values except through the fast path.

Reset
REQ-023 While i_rst_n is low at a rising edge, the block SHALL set:
- state = IDLE and counter = 0;
- all operand, product and remainder registers = 0;
- o_Result_32 = 0, o_Done_1 = 0, o_Busy_1 = 0, o_Ready_1 = 1 (from the following cycle).
REQ-024 Reset asserted mid-operation SHALL discard the operation with no o_Done_1 pulse.

Configuration
REQ-025 With macro MDU_DIV_EN defined, all eight operations SHALL be supported as specified.
REQ-026 Without MDU_DIV_EN, the divider datapath SHALL be absent; ops 100-111 SHALL take the fast path (o_Done_1 at N+1) with o_Result_32 = 0.

Structure
REQ-027 Package mdu_pkg SHALL hold:
- the op encodings;
- the state enum;
- localparam MDU_ITER = 32;
- the special-case constants 0x80000000 and 0xFFFFFFFF.
REQ-028 A single sub-module mdu_addsub33 (33-bit add/subtract with carry-in) SHALL be shared by the multiply and divide iterations.

Verification
REQ-029 MUL 7 x 0xFFFFFFFD (-3) -> o_Result_32 = 0xFFFFFFEB, o_Done_1 exactly at N+34, o_Busy_1 high N..N+33.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-032 Special cases, each with o_Done_1 at N+1:
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000;
- REM of the same operands -> 0;
- DIVU 5 / 0 -> 0xFFFFFFFF;
- REMU 5 / 0 -> 5.
REQ-033 MUL accepted at N, i_Flush_1 at N+10 -> IDLE and o_Ready_1 high at N+11, no o_Done_1, o_Result_32 unchanged; the same check with i_rst_n low at N+10 additionally gives o_Result_32 = 0.
REQ-034 i_Valid_1 held high continuously in back-to-back use -> the second request is accepted at N+35 only, with no double acceptance.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and constants for the sequential multiply/divide unit.
package mdu_pkg;

  localparam int          MDU_ITER     = 32;
  localparam logic [31:0] MDU_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] MDU_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic op1_signed(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op2_signed(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_addsub33.sv
// 33-bit adder/subtractor shared by the multiply and divide iterations.
module mdu_addsub33 (
  input  logic [32:0] i_a,
  input  logic [32:0] i_b,
  input  logic        i_sub,
  input  logic        i_cin,
  output logic [32:0] o_sum
);

  assign o_sum = i_a + (i_b ^ {33{i_sub}}) + {32'b0, i_cin};

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU/REM/REMU finish at once with 0.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_Valid_1,
  output logic              o_Ready_1,
  input  logic [2:0]        i_MDUOp_3,
  input  logic [DATA_W-1:0] i_Operand1_32,
  input  logic [DATA_W-1:0] i_Operand2_32,
  input  logic              i_Flush_1,
  output logic              o_Busy_1,
  output logic              o_Done_1,
  output logic [DATA_W-1:0] o_Result_32
);

  mdu_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [63:0] prod_q, prod_d;
  logic        neg_q, neg_d;
`ifdef MDU_DIV_EN
  logic        rneg_q, rneg_d;
`endif
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  mdu_op_e     in_op;
  logic        s1, s2;
  logic [31:0] mag1, mag2;
  logic        accept;
  logic        fast;
  logic [31:0] fast_result;
  logic [32:0] add_a, add_b, add_sum;
  logic        add_sub;
  logic [63:0] prod_fix;
  logic [31:0] fix_result;

  assign in_op  = mdu_op_e'(i_MDUOp_3);
  assign accept = i_Valid_1 & (state_q == ST_IDLE) & ~i_Flush_1;
  assign s1     = op1_signed(in_op) & i_Operand1_32[31];
  assign s2     = op2_signed(in_op) & i_Operand2_32[31];
  assign mag1   = s1 ? -i_Operand1_32 : i_Operand1_32;
  assign mag2   = s2 ? -i_Operand2_32 : i_Operand2_32;

  // Divide-by-zero and signed overflow bypass the iterations entirely.
  always_comb begin
    fast        = 1'b0;
    fast_result = '0;
`ifdef MDU_DIV_EN
    if (is_div(in_op)) begin
      if (i_Operand2_32 == '0) begin
        fast        = 1'b1;
        fast_result = in_op[1] ? i_Operand1_32 : MDU_ALL_ONES;
      end else if (op1_signed(in_op) && i_Operand1_32 == MDU_INT_MIN &&
                   i_Operand2_32 == MDU_ALL_ONES) begin
        fast        = 1'b1;
        fast_result = in_op[1] ? 32'd0 : MDU_INT_MIN;
      end
    end
`else
    fast = is_div(in_op);
`endif
  end

  // prod_q holds {hi, multiplier} while multiplying and {remainder, quotient} while dividing.
  always_comb begin
    add_a   = {1'b0, prod_q[63:32]};
    add_b   = prod_q[0] ? {1'b0, a_q} : 33'd0;
    add_sub = 1'b0;
`ifdef MDU_DIV_EN
    if (is_div(op_q)) begin
      add_a   = prod_q[63:31];
      add_b   = {1'b0, a_q};
      add_sub = 1'b1;
    end
`endif
  end

  mdu_addsub33 u_addsub (
    .i_a   (add_a),
    .i_b   (add_b),
    .i_sub (add_sub),
    .i_cin (add_sub),
    .o_sum (add_sum)
  );

  always_comb begin
    prod_fix   = neg_q ? -prod_q : prod_q;
    fix_result = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
`ifdef MDU_DIV_EN
    if (is_div(op_q)) begin
      if (op_q[1]) fix_result = rneg_q ? -prod_q[63:32] : prod_q[63:32];
      else         fix_result = neg_q  ? -prod_q[31:0]  : prod_q[31:0];
    end
`endif
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
`ifdef MDU_DIV_EN
    rneg_d   = rneg_q;
`endif
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = in_op;
          cnt_d  = '0;
          a_d    = mag2;
          prod_d = {32'd0, mag1};
          neg_d  = s1 ^ s2;
`ifdef MDU_DIV_EN
          rneg_d = s1;
`endif
          if (fast) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = fast_result;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d  = cnt_q + 6'd1;
        prod_d = {add_sum, prod_q[31:1]};
`ifdef MDU_DIV_EN
        // A negative trial difference means the divisor did not fit: keep the shifted remainder.
        if (is_div(op_q)) begin
          prod_d = add_sum[32] ? {prod_q[62:0], 1'b0}
                               : {add_sum[31:0], prod_q[30:0], 1'b1};
        end
`endif
        if (cnt_q == 6'(MDU_ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        result_d = fix_result;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (i_Flush_1) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: datapath registers are cleared along with the FSM so nothing stale survives reset.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      a_q      <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
`ifdef MDU_DIV_EN
      rneg_q   <= 1'b0;
`endif
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d on the same edge.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
`ifdef MDU_DIV_EN
      rneg_q   <= rneg_d;
`endif
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign o_Ready_1   = (state_q == ST_IDLE);
  assign o_Busy_1    = accept | (state_q == ST_CALC) | (state_q == ST_FIX);
  assign o_Done_1    = done_q;
  assign o_Result_32 = result_q;

endmodule
